// File: rtl/pwm_ramp_pkg.sv
// Shared constants for the PWM ramp controller: register addresses,
// CTRL bit positions and the per-channel ramp FSM state type.
package pwm_ramp_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_PRESC = 3'd1;
  localparam logic [2:0] ADDR_TGT1  = 3'd2;
  localparam logic [2:0] ADDR_TGT2  = 3'd3;
  localparam logic [2:0] ADDR_STEP  = 3'd4;
  localparam logic [2:0] ADDR_IRQ   = 3'd5;

  localparam int CTRL_EN1 = 0;
  localparam int CTRL_EN2 = 1;
  localparam int CTRL_GO1 = 2;
  localparam int CTRL_GO2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2
  } chan_state_e;

endpackage

// File: rtl/pwm_ramp_chan.sv
// One ramp channel: waits a programmable number of PWM periods, then moves
// the live pulse width one saturating step toward the target.
module pwm_ramp_chan
  import pwm_ramp_pkg::*;
#(
  parameter int INTERVAL_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  go,
  input  logic                  period_end,
  input  logic [7:0]            target,
  input  logic [7:0]            step,
  input  logic [INTERVAL_W-1:0] interval,
  output logic [7:0]            width,
  output logic                  busy,
  output logic                  done
);

  chan_state_e           state;
  logic [INTERVAL_W-1:0] ic;
  logic [INTERVAL_W-1:0] ivl_q;
  logic [7:0]            step_q;
  logic [7:0]            next_w;

  // Move w toward t by s, clamped at t; 9-bit intermediates avoid wraparound.
  function automatic logic [7:0] ramp_next(input logic [7:0] w,
                                           input logic [7:0] t,
                                           input logic [7:0] s);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, w} + {1'b0, s};
    dn = {1'b0, w} - {1'b0, s};
    if (s == 8'd0) return t;
    if (w < t) return (up > {1'b0, t}) ? t : up[7:0];
    if (w > t) return (dn[8] || (dn[7:0] < t)) ? t : dn[7:0];
    return w;
  endfunction

  assign next_w = ramp_next(width, target, step_q);

  // Ramp FSM; disable overrides everything and parks the width at 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      ic     <= '0;
      ivl_q  <= INTERVAL_W'(1);
      step_q <= 8'd0;
      width  <= 8'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        ic    <= '0;
        width <= 8'd0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (go) begin
              state  <= ST_WAIT;
              ic     <= '0;
              busy   <= 1'b1;
              step_q <= step;
              ivl_q  <= interval;
            end
          end
          ST_WAIT: begin
            if (period_end) begin
              if (ic == ivl_q - INTERVAL_W'(1)) state <= ST_STEP;
              else ic <= ic + INTERVAL_W'(1);
            end
          end
          ST_STEP: begin
            width <= next_w;
            if (next_w == target) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= ST_WAIT;
              ic     <= '0;
              step_q <= step;
              ivl_q  <= interval;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Register-programmed ramp controller feeding the dual-channel 8-bit PWM
// generator. Holds the write-only register file, a period tracker that
// mirrors the generator's counters, and two ramp channels.
// Optional macro PWM_RAMP_IRQ_EN adds a sticky irq output and register 5.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PRESCALER = 32'd1,
  parameter int          INTERVAL_W        = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [7:0]  pwm_control_register,
  output logic [31:0] pwm_prescaler,
  output logic [7:0]  pwm_pulse_width_1,
  output logic [7:0]  pwm_pulse_width_2,
  output logic [1:0]  busy,
  output logic [1:0]  done
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [1:0]            en_sh;
  logic [31:0]           presc_sh;
  logic [7:0]            tgt1;
  logic [7:0]            tgt2;
  logic [7:0]            step1;
  logic [7:0]            step2;
  logic [INTERVAL_W-1:0] ivl;
  logic [1:0]            en_nx;
  logic [31:0]           presc_nx;
  logic [1:0]            go;
  logic [1:0]            ctrl_q;
  logic [31:0]           pc;
  logic [7:0]            qc;
  logic                  any_en;
  logic                  period_end;

  assign any_en               = |ctrl_q;
  assign period_end           = any_en && (pc == 32'd0) && (qc == 8'hFF);
  assign pwm_control_register = {6'b0, ctrl_q};

  // Shadow values as they will be after this cycle's write, plus GO strobes.
  always_comb begin
    en_nx    = en_sh;
    presc_nx = presc_sh;
    go       = 2'b00;
    if (wr_en && (wr_addr == ADDR_CTRL)) begin
      en_nx = {wr_data[CTRL_EN2], wr_data[CTRL_EN1]};
      go    = {wr_data[CTRL_GO2], wr_data[CTRL_GO1]};
    end
    if (wr_en && (wr_addr == ADDR_PRESC))
      presc_nx = (wr_data == 32'd0) ? 32'd1 : wr_data;
  end

  // Register file. The prescaler shadow starts at the default so that the
  // idle-time shadow copy keeps the reset prescaler on the output.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      en_sh    <= 2'b00;
      presc_sh <= DEFAULT_PRESCALER;
      tgt1     <= 8'd0;
      tgt2     <= 8'd0;
      step1    <= 8'd0;
      step2    <= 8'd0;
      ivl      <= INTERVAL_W'(1);
    end else begin
      en_sh    <= en_nx;
      presc_sh <= presc_nx;
      if (wr_en && (wr_addr == ADDR_TGT1)) tgt1 <= wr_data[7:0];
      if (wr_en && (wr_addr == ADDR_TGT2)) tgt2 <= wr_data[7:0];
      if (wr_en && (wr_addr == ADDR_STEP)) begin
        step1 <= wr_data[7:0];
        step2 <= wr_data[15:8];
        ivl   <= (wr_data[16 +: INTERVAL_W] == '0) ? INTERVAL_W'(1)
                                                   : wr_data[16 +: INTERVAL_W];
      end
    end
  end

  // Generator config changes only on period boundaries or while idle;
  // clearing an enable always lands immediately.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_q        <= 2'b00;
      pwm_prescaler <= DEFAULT_PRESCALER;
    end else if (period_end || !any_en) begin
      ctrl_q        <= en_nx;
      pwm_prescaler <= presc_nx;
    end else begin
      ctrl_q <= ctrl_q & en_nx;
    end
  end

  // Period tracker mirroring the generator's prescale and period counters.
  always_ff @(posedge clock) begin
    if (!reset_n || !any_en) begin
      pc <= 32'd0;
      qc <= 8'd0;
    end else begin
      pc <= (pc >= pwm_prescaler - 32'd1) ? 32'd0 : pc + 32'd1;
      if (pc == 32'd0) qc <= qc + 8'd1;
    end
  end

  pwm_ramp_chan #(.INTERVAL_W(INTERVAL_W)) u_chan1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en_nx[0]),
    .go         (go[0]),
    .period_end (period_end),
    .target     (tgt1),
    .step       (step1),
    .interval   (ivl),
    .width      (pwm_pulse_width_1),
    .busy       (busy[0]),
    .done       (done[0])
  );

  pwm_ramp_chan #(.INTERVAL_W(INTERVAL_W)) u_chan2 (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en_nx[1]),
    .go         (go[1]),
    .period_end (period_end),
    .target     (tgt2),
    .step       (step2),
    .interval   (ivl),
    .width      (pwm_pulse_width_2),
    .busy       (busy[1]),
    .done       (done[1])
  );

`ifdef PWM_RAMP_IRQ_EN
  // Sticky interrupt: any done sets it, a write of 1 to IRQ clears it,
  // and a simultaneous set wins.
  always_ff @(posedge clock) begin
    if (!reset_n) irq <= 1'b0;
    else if (|done) irq <= 1'b1;
    else if (wr_en && (wr_addr == ADDR_IRQ) && wr_data[0]) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with hand-computed expectations.
module tb_pwm_ramp_ctrl;

  logic        clock;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  pwm_control_register;
  logic [31:0] pwm_prescaler;
  logic [7:0]  pwm_pulse_width_1;
  logic [7:0]  pwm_pulse_width_2;
  logic [1:0]  busy;
  logic [1:0]  done;
`ifdef PWM_RAMP_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dcnt0  = 0;
  int dcnt1  = 0;

  pwm_ramp_ctrl #(
    .DEFAULT_PRESCALER (32'd5),
    .INTERVAL_W        (16)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .pwm_control_register (pwm_control_register),
    .pwm_prescaler        (pwm_prescaler),
    .pwm_pulse_width_1    (pwm_pulse_width_1),
    .pwm_pulse_width_2    (pwm_pulse_width_2),
    .busy                 (busy),
    .done                 (done)
`ifdef PWM_RAMP_IRQ_EN
    ,
    .irq                  (irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done[0]) dcnt0 <= dcnt0 + 1;
    if (done[1]) dcnt1 <= dcnt1 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  // Wait for a width change on channel ch; on timeout v keeps the old value.
  task automatic wait_change(input int ch, input int budget, output logic [7:0] v, output int t);
    logic [7:0] old;
    logic [7:0] cur;
    old = (ch == 1) ? pwm_pulse_width_1 : pwm_pulse_width_2;
    v = old;
    t = -100000;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cur = (ch == 1) ? pwm_pulse_width_1 : pwm_pulse_width_2;
      if (cur != old) begin
        v = cur;
        t = cyc;
        break;
      end
    end
  endtask

  logic [7:0] v;
  int t0, t1, t2, t3;

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 32'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    check_eq("rst_presc", pwm_prescaler, 32'd5);
    check_eq("rst_ctrl",  {24'd0, pwm_control_register}, 32'd0);
    check_eq("rst_w1",    {24'd0, pwm_pulse_width_1}, 32'd0);
    check_eq("rst_w2",    {24'd0, pwm_pulse_width_2}, 32'd0);
    check_eq("rst_busy",  {30'd0, busy}, 32'd0);

    // Ramp up 0 -> 4 -> 8 -> 10, interval 1, prescaler 1
    wr(3'd1, 32'd1);
    check_eq("presc_1", pwm_prescaler, 32'd1);
    wr(3'd2, 32'd10);
    wr(3'd4, 32'h0001_0004);
    wr(3'd0, 32'h5);
    t0 = cyc;
    check_eq("up_ctrl", {24'd0, pwm_control_register}, 32'd1);
    check_eq("up_busy", {30'd0, busy}, 32'd1);
    wait_change(1, 700, v, t1);
    check_eq("up_w_a", {24'd0, v}, 32'd4);
    check_eq("up_lat", t1 - t0, 257);
    wait_change(1, 700, v, t2);
    check_eq("up_w_b", {24'd0, v}, 32'd8);
    check_eq("up_gap_b", t2 - t1, 256);
    wait_change(1, 700, v, t3);
    check_eq("up_w_c", {24'd0, v}, 32'd10);
    check_eq("up_gap_c", t3 - t2, 256);
    repeat (2) @(negedge clock);
    check_eq("up_done", dcnt0, 1);
    check_eq("up_busy_end", {30'd0, busy}, 32'd0);

    // Ramp down 10 -> 7 -> 4 -> 2, step 3, interval 2
    wr(3'd2, 32'd2);
    wr(3'd4, 32'h0002_0003);
    wr(3'd0, 32'h5);
    wait_change(1, 1200, v, t1);
    check_eq("dn_w_a", {24'd0, v}, 32'd7);
    wait_change(1, 1200, v, t2);
    check_eq("dn_w_b", {24'd0, v}, 32'd4);
    check_eq("dn_gap_b", t2 - t1, 512);
    wait_change(1, 1200, v, t3);
    check_eq("dn_w_c", {24'd0, v}, 32'd2);
    check_eq("dn_gap_c", t3 - t2, 512);
    repeat (2) @(negedge clock);
    check_eq("dn_done", dcnt0, 2);

    // Step 0 jumps straight to target
    wr(3'd4, 32'h0000_0000);
    wr(3'd2, 32'd200);
    wr(3'd0, 32'h5);
    wait_change(1, 700, v, t1);
    check_eq("jump_w", {24'd0, v}, 32'd200);
    repeat (2) @(negedge clock);
    check_eq("jump_done", dcnt0, 3);

    // Disable mid-ramp: width and busy clear next cycle, no done
    wr(3'd4, 32'h0001_0001);
    wr(3'd2, 32'd100);
    wr(3'd0, 32'h5);
    wait_change(1, 700, v, t1);
    check_eq("mid_w", {24'd0, v}, 32'd199);
    wr(3'd0, 32'h0);
    check_eq("dis_w1",   {24'd0, pwm_pulse_width_1}, 32'd0);
    check_eq("dis_busy", {30'd0, busy}, 32'd0);
    check_eq("dis_ctrl", {24'd0, pwm_control_register}, 32'd0);
    repeat (600) @(negedge clock);
    check_eq("dis_nodone", dcnt0, 3);
    check_eq("dis_w1_hold", {24'd0, pwm_pulse_width_1}, 32'd0);
    wr(3'd1, 32'd3);
    check_eq("presc_3", pwm_prescaler, 32'd3);
    wr(3'd1, 32'd0);
    check_eq("presc_0", pwm_prescaler, 32'd1);

    // Both channels: ch1 0->100->200->250, ch2 0->5->10->12
    wr(3'd4, 32'h0001_0564);
    wr(3'd2, 32'd250);
    wr(3'd3, 32'd12);
    wr(3'd0, 32'hF);
    check_eq("dual_ctrl", {24'd0, pwm_control_register}, 32'd3);
    check_eq("dual_busy", {30'd0, busy}, 32'd3);
    wait_change(1, 700, v, t1);
    check_eq("dual_w1_a", {24'd0, v}, 32'd100);
    check_eq("dual_w2_a", {24'd0, pwm_pulse_width_2}, 32'd5);
    wait_change(1, 700, v, t1);
    check_eq("dual_w1_b", {24'd0, v}, 32'd200);
    check_eq("dual_w2_b", {24'd0, pwm_pulse_width_2}, 32'd10);
    wait_change(1, 700, v, t1);
    check_eq("dual_w1_c", {24'd0, v}, 32'd250);
    check_eq("dual_w2_c", {24'd0, pwm_pulse_width_2}, 32'd12);
    repeat (2) @(negedge clock);
    check_eq("dual_done1", dcnt0, 4);
    check_eq("dual_done2", dcnt1, 1);

    // Saturation: ch1 250 + 255 clamps to 255; ch2 12 -> 7 -> 2 -> 0
    wr(3'd2, 32'd255);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'h0001_05FF);
    wr(3'd0, 32'hF);
    wait_change(2, 700, v, t1);
    check_eq("sat_w2_a", {24'd0, v}, 32'd7);
    check_eq("sat_w1", {24'd0, pwm_pulse_width_1}, 32'd255);
    @(negedge clock);
    check_eq("sat_busy", {30'd0, busy}, 32'd2);
    wait_change(2, 700, v, t2);
    check_eq("sat_w2_b", {24'd0, v}, 32'd2);
    check_eq("sat_gap", t2 - t1, 256);
    wait_change(2, 700, v, t3);
    check_eq("sat_w2_c", {24'd0, v}, 32'd0);
    repeat (2) @(negedge clock);
    check_eq("sat_w1_hold", {24'd0, pwm_pulse_width_1}, 32'd255);
    check_eq("sat_done1", dcnt0, 5);
    check_eq("sat_done2", dcnt1, 2);
    check_eq("sat_busy_end", {30'd0, busy}, 32'd0);

`ifdef PWM_RAMP_IRQ_EN
    check_eq("irq_set", {31'd0, irq}, 32'd1);
    wr(3'd5, 32'd1);
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
